// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and baud-divider helper.
// Used by both the receive path (uart_rx_axis) and the transmit path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int baud_div(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  // Parity selection is given as a short string; anything unrecognised means even.
  function automatic int parity_mode(input logic [31:0] s);
    if (s == "none")
      return PAR_NONE;
    else if (s == {8'h00, "odd"})
      return PAR_ODD;
    else
      return PAR_EVEN;
  endfunction

endpackage

// File: rtl/rx_stream_fifo.sv
// Synchronous show-ahead FIFO with simultaneous read/write; full/empty derived from count.
`timescale 1ns/1ps
module rx_stream_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_fire;
  logic          rd_fire;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A write into a full FIFO is accepted only when a read frees the head slot this cycle.
  assign wr_fire = wr_en && (!full || rd_en);
  assign rd_fire = rd_en && !empty;

  // Head is masked while empty so the output reads zero rather than stale storage.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver -> FIFO -> AXI-Stream master with parity/framing checks.
// Optional UART_RX_AXIS_TUSER_EN: keep errored characters and flag them on m_axis_tuser.
`timescale 1ns/1ps
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int          CLK_RATE = 50000000,
  parameter int          BAUD     = 115200,
  parameter int          WIDTH    = 8,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] PARITY   = "even"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic [WIDTH-1:0] m_axis_data,
  output logic             m_axis_valid,
  input  logic             m_axis_ready,
`ifdef UART_RX_AXIS_TUSER_EN
  output logic             m_axis_tuser,
`endif
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow
);

  localparam int BAUD_DIV = baud_div(CLK_RATE, BAUD);
  localparam int PAR_MODE = parity_mode(PARITY);
  localparam int CW       = $clog2(BAUD_DIV) + 1;
  localparam int BW       = $clog2(WIDTH) + 1;
`ifdef UART_RX_AXIS_TUSER_EN
  localparam int FW       = WIDTH + 1;
`else
  localparam int FW       = WIDTH;
`endif

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  logic [1:0]       sync_q, sync_d;
  logic             rxs;
  uart_state_e      state_q, state_d;
  logic [CW-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic             commit;
  logic             char_err;
  logic             push_req;
  logic [FW-1:0]    fifo_wr_data;
  logic [FW-1:0]    fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  assign sync_d = {sync_q[0], uart_rx};
  assign rxs    = sync_q[1];

  // Counters restart at zero on every state change, so each state measures its own interval.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d    = ST_START;
          baud_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          state_d    = rxs ? ST_IDLE : ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rxs, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == BIT_LAST)
            state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          else
            bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = ST_STOP;
          if (PAR_MODE == PAR_ODD)
            par_bad_d = ((~^shift_q) != rxs);
          else
            par_bad_d = ((^shift_q) != rxs);
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          commit     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
    end
  end

  // In the commit cycle rxs still holds the stop-bit sample.
  assign char_err   = par_bad_q || !rxs;
  assign parity_err = commit && par_bad_q;
  assign frame_err  = commit && !rxs;
  assign pop        = m_axis_valid && m_axis_ready;

`ifdef UART_RX_AXIS_TUSER_EN
  assign push_req     = commit;
  assign fifo_wr_data = {char_err, shift_q};
  assign m_axis_data  = fifo_head[WIDTH-1:0];
  assign m_axis_tuser = fifo_head[WIDTH];
`else
  assign push_req     = commit && !char_err;
  assign fifo_wr_data = shift_q;
  assign m_axis_data  = fifo_head;
`endif

  assign overflow     = push_req && fifo_full && !pop;
  assign m_axis_valid = !fifo_empty;

  rx_stream_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_req),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: directed frames plus randomized traffic
// compared against a character-level model (expected beat queue and error counts).
`timescale 1ns/1ps
module tb_uart_rx_axis;

  localparam int CLK_RATE = 1600;
  localparam int BAUD     = 100;
  localparam int BIT_CLKS = CLK_RATE / BAUD;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;

  typedef struct {
    logic [7:0] data;
    logic       user;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       m_axis_ready = 1'b0;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_tuser;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int    compared = 0;
  int    mismatched = 0;
  beat_t expQ[$];
  beat_t popped;
  int    modelCount = 0;
  int    expBeats = 0, expParity = 0, expFrame = 0, expOverflow = 0;
  int    gotBeats = 0, gotParity = 0, gotFrame = 0, gotOverflow = 0;
  bit    randomReady = 1'b0;
  bit    prevStall = 1'b0;
  logic [7:0] stallData;

  always #5 clk = ~clk;

  uart_rx_axis #(
    .CLK_RATE (CLK_RATE),
    .BAUD     (BAUD),
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rx      (uart_rx),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
`ifdef UART_RX_AXIS_TUSER_EN
    .m_axis_tuser (m_axis_tuser),
`endif
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

`ifndef UART_RX_AXIS_TUSER_EN
  assign m_axis_tuser = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change just after the rising edge; the monitor samples on the falling edge.
  task automatic waitClocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic b);
    uart_rx = b;
    waitClocks(BIT_CLKS);
  endtask

  // Character-level model: decides what the line frame should produce before it is sent.
  task automatic modelFrame(input logic [7:0] d, input bit badPar, input bit badStop);
    bit keep;
    bit err;
    err = badPar || badStop;
    if (badPar) expParity++;
    if (badStop) expFrame++;
`ifdef UART_RX_AXIS_TUSER_EN
    keep = 1'b1;
`else
    keep = !err;
`endif
    if (keep) begin
      if (modelCount >= DEPTH) begin
        expOverflow++;
      end else begin
        expQ.push_back('{data: d, user: err});
        modelCount++;
        expBeats++;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit badPar, input bit badStop);
    modelFrame(d, badPar, badStop);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
    driveBit((^d) ^ badPar);
    driveBit(!badStop);
    uart_rx = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 4000 && expQ.size() != 0; i++) waitClocks(1);
    checkOutput({tag, "_drained"}, expQ.size(), 0);
    waitClocks(4);
    checkOutput({tag, "_beats"}, gotBeats, expBeats);
    checkOutput({tag, "_parity_err"}, gotParity, expParity);
    checkOutput({tag, "_frame_err"}, gotFrame, expFrame);
    checkOutput({tag, "_overflow"}, gotOverflow, expOverflow);
  endtask

  task automatic checkResetOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_valid"}, m_axis_valid, 0);
    checkOutput({tag, "_data"}, m_axis_data, 0);
    checkOutput({tag, "_tuser"}, m_axis_tuser, 0);
    checkOutput({tag, "_errs"}, {parity_err, frame_err, overflow}, 0);
  endtask

  // Monitor: counts pulses, pops the model on each handshake and checks head stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (parity_err) gotParity++;
      if (frame_err) gotFrame++;
      if (overflow) gotOverflow++;
      if (prevStall && m_axis_valid)
        checkOutput("stall_data_stable", m_axis_data, stallData);
      if (m_axis_valid && m_axis_ready) begin
        gotBeats++;
        checkOutput("beat_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          popped = expQ.pop_front();
          modelCount--;
          checkOutput("beat_data", m_axis_data, popped.data);
`ifdef UART_RX_AXIS_TUSER_EN
          checkOutput("beat_tuser", m_axis_tuser, popped.user);
`endif
        end
      end
      prevStall = m_axis_valid && !m_axis_ready;
      stallData = m_axis_data;
    end
  end

  always @(posedge clk) begin
    if (randomReady) begin
      #1;
      m_axis_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    checkResetOutputs("reset");
    waitClocks(3);
    rst_n = 1'b1;
    m_axis_ready = 1'b1;
    waitClocks(20);

    applyStimulus(8'hA5, 1'b0, 1'b0);
    waitDrain("t1_good");

    applyStimulus(8'h3C, 1'b1, 1'b0);
    waitDrain("t2_parity");

    applyStimulus(8'h55, 1'b0, 1'b1);
    waitClocks(2 * BIT_CLKS);
    waitDrain("t3_frame");

    uart_rx = 1'b0;
    waitClocks(4);
    uart_rx = 1'b1;
    waitClocks(3 * BIT_CLKS);
    waitDrain("t4_glitch");

    m_axis_ready = 1'b0;
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    waitClocks(BIT_CLKS);
    checkOutput("t5_overflow_before_drain", gotOverflow, expOverflow);
    checkOutput("t5_held_beats", gotBeats, expBeats - DEPTH);
    m_axis_ready = 1'b1;
    waitDrain("t5_backpressure");

    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'(8'h77 >> i));
    rst_n = 1'b0;
    uart_rx = 1'b1;
    checkResetOutputs("t6_in_reset");
    waitClocks(3);
    rst_n = 1'b1;
    waitClocks(3 * BIT_CLKS);
    applyStimulus(8'h88, 1'b0, 1'b0);
    waitDrain("t6_after_reset");

    randomReady = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit badPar;
      bit badStop;
      d = 8'($urandom_range(0, 255));
      badPar = ($urandom_range(0, 7) == 0);
      badStop = ($urandom_range(0, 7) == 0);
      applyStimulus(d, badPar, badStop);
      if (badStop) waitClocks(2 * BIT_CLKS);
      waitClocks($urandom_range(0, 40));
    end
    waitDrain("random");
    randomReady = 1'b0;
    waitClocks(2);
    m_axis_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
